// File: rtl/rle_pkg.sv
// Shared FSM state encoding and default encoder constants for the RLE encoder.
package rle_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COUNT    = 3'd1,
    EMIT_ESC = 3'd2,
    EMIT_VAL = 3'd3,
    EMIT_CNT = 3'd4,
    EMIT_LIT = 3'd5,
    BYPASS   = 3'd6
  } rle_state_e;

  localparam logic [7:0]  RLE_ESC     = 8'h1B;
  localparam int unsigned RLE_MIN_RUN = 3;

endpackage

// File: rtl/rle_out_reg.sv
// Single-entry output register: loads when empty or draining, holds data/last stable under backpressure.
module rle_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic              last_q;

  assign in_ready = !valid_q || m_ready;
  assign m_valid  = valid_q;
  assign m_data   = data_q;
  assign m_last   = last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
      last_q  <= in_last;
    end else if (m_ready) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/rle_encoder_p.sv
// Run-length encoder: short non-escape runs pass as literals, everything else as ESC,V,L triples.
// Both ports: a symbol moves only on a rising edge where valid and ready are both high.
module rle_encoder_p
  import rle_pkg::*;
#(
  parameter int              DATA_W  = 8,
  parameter int              CNT_W   = 8,
  parameter logic [DATA_W-1:0] ESC   = DATA_W'(RLE_ESC),
  parameter int              MIN_RUN = RLE_MIN_RUN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bypass,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  run_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_RUN);

  rle_state_e        state_q, state_d;
  logic [DATA_W-1:0] val_q, val_d, brk_q, brk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, rem_q, rem_d;
  logic              brk_vld_q, brk_vld_d, brk_last_q, brk_last_d, last_q, last_d;
  logic              rdy_en_q;

  logic              o_valid, o_last, o_ready;
  logic [DATA_W-1:0] o_data;

  logic              start, done, xfer, bp_rdy;
  logic [DATA_W-1:0] start_v;
  logic [CNT_W-1:0]  start_l, cnt_inc;
  logic              start_last;

  assign state   = state_q;
  assign run_cnt = cnt_q;
  assign xfer    = m_valid && m_ready;
  assign cnt_inc = cnt_q + CNT_ONE;
  assign bp_rdy  = !m_valid || (m_ready && !m_last);

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    brk_d      = brk_q;
    brk_vld_d  = brk_vld_q;
    brk_last_d = brk_last_q;
    last_d     = last_q;
    s_ready    = 1'b0;
    o_valid    = 1'b0;
    o_data     = val_q;
    o_last     = 1'b0;
    start      = 1'b0;
    start_v    = s_data;
    start_l    = CNT_ONE;
    start_last = s_last;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = rdy_en_q;
        if (rdy_en_q && s_valid) begin
          if (bypass) begin
            state_d = BYPASS;
            o_valid = 1'b1;
            o_data  = s_data;
            o_last  = s_last;
          end else if (s_last || CNT_ONE == CNT_MAX) begin
            start = 1'b1;
          end else begin
            state_d = COUNT;
            val_d   = s_data;
            cnt_d   = CNT_ONE;
          end
        end
      end
      COUNT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_data != val_q) begin
            // The breaking symbol is kept here and seeds the next run after emission.
            brk_d      = s_data;
            brk_vld_d  = 1'b1;
            brk_last_d = s_last;
            start      = 1'b1;
            start_v    = val_q;
            start_l    = cnt_q;
            start_last = 1'b0;
          end else if (s_last || cnt_inc == CNT_MAX) begin
            start   = 1'b1;
            start_v = val_q;
            start_l = cnt_inc;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      EMIT_ESC: if (xfer) begin
        o_valid = 1'b1;
        o_data  = val_q;
        state_d = EMIT_VAL;
      end
      EMIT_VAL: if (xfer) begin
        o_valid = 1'b1;
        o_data  = DATA_W'(cnt_q);
        o_last  = last_q;
        state_d = EMIT_CNT;
      end
      EMIT_CNT: done = xfer;
      EMIT_LIT: if (xfer) begin
        if (rem_q > CNT_ONE) begin
          o_valid = 1'b1;
          o_data  = val_q;
          o_last  = last_q && (rem_q == CNT_TWO);
          rem_d   = rem_q - CNT_ONE;
        end else begin
          done = 1'b1;
        end
      end
      BYPASS: begin
        s_ready = bp_rdy;
        if (bp_rdy && s_valid) begin
          o_valid = 1'b1;
          o_data  = s_data;
          o_last  = s_last;
        end
        if (xfer && m_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      if (brk_vld_q) begin
        brk_vld_d = 1'b0;
        if (brk_last_q) begin
          start      = 1'b1;
          start_v    = brk_q;
          start_l    = CNT_ONE;
          start_last = 1'b1;
        end else begin
          state_d = COUNT;
          val_d   = brk_q;
          cnt_d   = CNT_ONE;
        end
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = 1'b0;
      end
    end

    // First symbol of an emission is loaded on the terminating edge itself.
    if (start) begin
      val_d   = start_v;
      cnt_d   = start_l;
      last_d  = start_last;
      o_valid = 1'b1;
      if (start_v == ESC || start_l >= MIN_C) begin
        state_d = EMIT_ESC;
        o_data  = ESC;
        o_last  = 1'b0;
      end else begin
        state_d = EMIT_LIT;
        o_data  = start_v;
        o_last  = start_last && (start_l == CNT_ONE);
        rem_d   = start_l;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      val_q      <= '0;
      brk_q      <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      brk_vld_q  <= 1'b0;
      brk_last_q <= 1'b0;
      last_q     <= 1'b0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      brk_q      <= brk_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      brk_vld_q  <= brk_vld_d;
      brk_last_q <= brk_last_d;
      last_q     <= last_d;
      rdy_en_q   <= 1'b1;
    end
  end

  rle_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (o_valid),
    .in_data  (o_data),
    .in_last  (o_last),
    .in_ready (o_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready)
  );

  // Loads are only issued when the output register is empty or draining.
  always_ff @(posedge clk) begin
    if (rst_n && o_valid) assert (o_ready);
  end

endmodule

// File: tb/tb_rle_encoder_p.sv
// Directed scoreboard bench for rle_encoder_p with default parameters.
module tb_rle_encoder_p;
  import rle_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bypass = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic [2:0] state;
  logic [7:0] run_cnt;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  rle_encoder_p dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bypass  (bypass),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .state   (state),
    .run_cnt (run_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_sym(input logic [7:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic chk_lat);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 500) begin
        check("send_timeout", 32'(n), 32'(0));
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    if (chk_lat) check("bypass_latency", 32'({m_valid, m_last, m_data}), 32'({1'b1, l, d}));
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_drained"}, 32'(exp_q.size()), 32'(0));
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_state"}, 32'(state), 32'(IDLE));
    check({name, "_run_cnt"}, 32'(run_cnt), 32'(0));
    check({name, "_m_valid"}, 32'(m_valid), 32'(0));
    check({name, "_m_last"}, 32'(m_last), 32'(0));
    check({name, "_m_data"}, 32'(m_data), 32'(0));
    check({name, "_s_ready"}, 32'(s_ready), 32'(0));
  endtask

  // Monitor: pops one expected symbol per output transfer.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", {m_last, m_data});
      end else begin
        e = exp_q.pop_front();
        check("out_symbol", 32'({m_last, m_data}), 32'(e));
      end
    end
  end

  task automatic stall_at_emit_val();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state != 3'(EMIT_VAL) && n < 300);
    check("stall_reach_emit_val", 32'(state), 32'(EMIT_VAL));
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_m_valid", 32'(m_valid), 32'(1));
      check("stall_m_data", 32'(m_data), 32'(8'hC6));
      check("stall_s_ready", 32'(s_ready), 32'(0));
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("s_ready_before_edge", 32'(s_ready), 32'(0));
    @(posedge clk);
    #1;
    check("s_ready_after_edge", 32'(s_ready), 32'(1));

    // AD,5E,5E,1B(last)
    expect_sym(8'hAD, 0); expect_sym(8'h5E, 0); expect_sym(8'h5E, 0);
    expect_sym(8'h1B, 0); expect_sym(8'h1B, 0); expect_sym(8'h01, 1);
    send(8'hAD, 0, 0); send(8'h5E, 0, 0); send(8'h5E, 0, 0); send(8'h1B, 1, 0);
    drain("mixed");

    // C6 x4, 88(last)
    expect_sym(8'h1B, 0); expect_sym(8'hC6, 0); expect_sym(8'h04, 0); expect_sym(8'h88, 1);
    for (int i = 0; i < 4; i++) send(8'hC6, 0, 0);
    send(8'h88, 1, 0);
    drain("run4");

    // 77 x258: max-length run then a 3-run
    expect_sym(8'h1B, 0); expect_sym(8'h77, 0); expect_sym(8'hFF, 0);
    expect_sym(8'h1B, 0); expect_sym(8'h77, 0); expect_sym(8'h03, 1);
    for (int i = 0; i < 258; i++) send(8'h77, i == 257, 0);
    drain("maxrun");

    // Same as run4 with backpressure while C6 is presented
    expect_sym(8'h1B, 0); expect_sym(8'hC6, 0); expect_sym(8'h04, 0); expect_sym(8'h88, 1);
    fork
      begin
        for (int i = 0; i < 4; i++) send(8'hC6, 0, 0);
        send(8'h88, 1, 0);
      end
      stall_at_emit_val();
    join
    drain("stall");

    // Threshold: a 2-run stays literal, a 3-run becomes a triple
    expect_sym(8'h33, 0); expect_sym(8'h33, 0);
    expect_sym(8'h1B, 0); expect_sym(8'h34, 0); expect_sym(8'h03, 1);
    send(8'h33, 0, 0); send(8'h33, 0, 0);
    send(8'h34, 0, 0); send(8'h34, 0, 0); send(8'h34, 1, 0);
    drain("threshold");

    // Reset in the middle of a 5A run discards it
    for (int i = 0; i < 6; i++) send(8'h5A, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_sym(8'h5A, 0); expect_sym(8'hEE, 1);
    send(8'h5A, 0, 0); send(8'hEE, 1, 0);
    drain("after_reset");

    // Bypass: each symbol one cycle later, unchanged
    bypass = 1'b1;
    expect_sym(8'h1B, 0); expect_sym(8'h1B, 0); expect_sym(8'h1B, 1);
    send(8'h1B, 0, 1); send(8'h1B, 0, 1); send(8'h1B, 1, 1);
    drain("bypass");
    check("bypass_back_to_idle", 32'(state), 32'(IDLE));
    bypass = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
